// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, fetching over req/ack into a one-entry buffer for IF/ID.
// Optional FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect flag.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pcplus4_f,
  output logic        fetch_busy,
  output logic        misalign_err
);
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, FLUSH} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, ibuf, ibuf_pc4, rpc_al;
  logic        ibuf_valid, consume, ack_f;
  assign rpc_al  = {redirect_pc[31:2], 2'b00};
  assign consume = ibuf_valid && !stall_f;
  assign ack_f   = state == FETCH && imem_ack;
  assign pc_n    = redirect ? rpc_al : ack_f ? imem_addr + 32'd4 : pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= BOOT;
    else state <= state_n;
  // An ack landing together with a redirect in FLUSH still retires the stale request.
  always_comb begin
    state_n = state;
    case (state)
      BOOT:  state_n = FETCH;
      FETCH: state_n = imem_ack ? (redirect ? FETCH : WAIT) : (redirect ? FLUSH : FETCH);
      WAIT:  state_n = (redirect || consume || !ibuf_valid) ? FETCH : WAIT;
      FLUSH: state_n = imem_ack ? FETCH : FLUSH;
      default: state_n = BOOT;
    endcase
  end
  always_comb begin
    imem_req   = state == FETCH || state == FLUSH;
    instr_f    = ibuf_valid ? ibuf : NOP_INSTR;
    pcplus4_f  = ibuf_valid ? ibuf_pc4 : 32'd0;
    fetch_busy = !ibuf_valid;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      ibuf       <= NOP_INSTR;
      ibuf_pc4   <= 32'd0;
      ibuf_valid <= 1'b0;
    end else begin
      pc         <= pc_n;
      if (state_n == FETCH) imem_addr <= pc_n;
      ibuf_valid <= redirect ? 1'b0 : ack_f ? 1'b1 : consume ? 1'b0 : ibuf_valid;
      if (ack_f && !redirect) begin
        ibuf     <= imem_rdata;
        ibuf_pc4 <= imem_addr + 32'd4;
      end
    end
`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) misalign_err <= 1'b0;
    else if (redirect && redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
`else
  logic unused_lo;
  assign unused_lo    = ^redirect_pc[1:0];
  assign misalign_err = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven cycle vectors plus hand sequences for reset and PC wrap.
module tb_if_fetch_unit;
`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic MIS = 1'b1;
`else
  localparam logic MIS = 1'b0;
`endif
  logic        clk = 0, reset = 1, stall_f = 0, redirect = 0, imem_ack = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic        imem_req, fetch_busy, misalign_err;
  logic [31:0] imem_addr, instr_f, pcplus4_f;
  int          total = 0, passed = 0;
  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_f(instr_f), .pcplus4_f(pcplus4_f), .fetch_busy(fetch_busy), .misalign_err(misalign_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        stall, redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr, instr, pc4;
    logic        busy, mis;
  } vec_t;
  vec_t vecs[24];
  function automatic vec_t v(logic s, logic r, logic [31:0] rp, logic a, logic [31:0] rd,
                             logic q, logic [31:0] ad, logic [31:0] in, logic [31:0] p4, logic b, logic m);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rp; t.ack = a; t.rdata = rd;
    t.req = q; t.addr = ad; t.instr = in; t.pc4 = p4; t.busy = b; t.mis = m & MIS;
    return t;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic drive(logic s, logic r, logic [31:0] rp, logic a, logic [31:0] rd);
    stall_f = s; redirect = r; redirect_pc = rp; imem_ack = a; imem_rdata = rd;
  endtask
  initial begin
    vecs[0]  = v(0,0,0,        0,0,            0,32'h0,  32'h0,       32'h0,  1,0);
    vecs[1]  = v(0,0,0,        1,32'h1111_1111,1,32'h0,  32'h0,       32'h0,  1,0);
    vecs[2]  = v(0,0,0,        0,0,            0,32'h0,  32'h1111_1111,32'h4, 0,0);
    vecs[3]  = v(0,0,0,        1,32'h2222_2222,1,32'h4,  32'h0,       32'h0,  1,0);
    for (int i = 4; i <= 8; i++)
      vecs[i] = v(1,0,0,       0,0,            0,32'h4,  32'h2222_2222,32'h8, 0,0);
    vecs[9]  = v(0,0,0,        0,0,            0,32'h4,  32'h2222_2222,32'h8, 0,0);
    vecs[10] = v(0,1,32'h100,  0,0,            1,32'h8,  32'h0,       32'h0,  1,0);
    vecs[11] = v(0,0,0,        0,0,            1,32'h8,  32'h0,       32'h0,  1,0);
    vecs[12] = v(0,0,0,        0,0,            1,32'h8,  32'h0,       32'h0,  1,0);
    vecs[13] = v(0,0,0,        1,32'hDEAD_BEEF,1,32'h8,  32'h0,       32'h0,  1,0);
    vecs[14] = v(0,0,0,        1,32'h3333_3333,1,32'h100,32'h0,       32'h0,  1,0);
    vecs[15] = v(0,1,32'h10,   0,0,            0,32'h100,32'h3333_3333,32'h104,0,0);
    vecs[16] = v(1,1,32'h40,   1,32'h4444_4444,1,32'h10, 32'h0,       32'h0,  1,0);
    vecs[17] = v(1,0,0,        0,0,            1,32'h40, 32'h0,       32'h0,  1,0);
    vecs[18] = v(1,0,0,        1,32'h5555_5555,1,32'h40, 32'h0,       32'h0,  1,0);
    vecs[19] = v(1,0,0,        1,32'h0000_0BAD,0,32'h40, 32'h5555_5555,32'h44,0,0);
    vecs[20] = v(0,0,0,        0,0,            0,32'h40, 32'h5555_5555,32'h44,0,0);
    vecs[21] = v(0,1,32'h203,  0,0,            1,32'h44, 32'h0,       32'h0,  1,0);
    vecs[22] = v(0,0,0,        1,32'h0000_0055,1,32'h44, 32'h0,       32'h0,  1,1);
    vecs[23] = v(0,0,0,        0,0,            1,32'h200,32'h0,       32'h0,  1,1);
    #2;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_f, 32'h0);
    chk("rst_pc4", pcplus4_f, 32'h0);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd1);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk) reset = 0;
    foreach (vecs[i]) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].ack, vecs[i].rdata);
      #1;
      total++;
      if (imem_req === vecs[i].req && imem_addr === vecs[i].addr && instr_f === vecs[i].instr &&
          pcplus4_f === vecs[i].pc4 && fetch_busy === vecs[i].busy && misalign_err === vecs[i].mis)
        passed++;
      else
        $display("FAIL vec%0d: got req=%b addr=%h instr=%h pc4=%h busy=%b mis=%b expected req=%b addr=%h instr=%h pc4=%h busy=%b mis=%b",
                 i, imem_req, imem_addr, instr_f, pcplus4_f, fetch_busy, misalign_err,
                 vecs[i].req, vecs[i].addr, vecs[i].instr, vecs[i].pc4, vecs[i].busy, vecs[i].mis);
    end
    // Mid-request asynchronous reset, then a spurious ack during BOOT.
    #2 reset = 1;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_busy", {31'd0, fetch_busy}, 32'd1);
    chk("async_rst_mis", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    reset = 0;
    drive(0, 0, 0, 1, 32'h0000_0999);
    #1;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    #1;
    chk("boot_ack_ignored", instr_f, 32'h0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h0000_0000);
    #1;
    chk("flush_addr", imem_addr, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h0000_0077);
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("wrap_instr", instr_f, 32'h0000_0077);
    chk("wrap_pc4", pcplus4_f, 32'h0);
    chk("wrap_busy", {31'd0, fetch_busy}, 32'd0);
    @(negedge clk);
    #1;
    chk("wrap_next_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
